// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the uRV fetch stage.
// URV_FETCH_BUFFER_EN selects the 2-deep response FIFO build (MAX_OUT = 2).
package rv_fetch_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

`ifdef URV_FETCH_BUFFER_EN
  localparam logic [2:0] MAX_OUT = 3'd2;
`else
  localparam logic [2:0] MAX_OUT = 3'd1;
`endif

  typedef enum logic {
    S_RESET = 1'b0,
    S_RUN   = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Two-entry {pc,ir} FIFO between instruction memory and the fetch output register.
module rv_fetch_fifo
  import rv_fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/rv_fetch.sv
// uRV instruction fetch: PC generation, in-order imem reads, stall hold, redirect with stale-response drop.
// URV_FETCH_BUFFER_EN adds a 2-entry response FIFO; otherwise a single hold register covers stalls.
//   state   | meaning
//   S_RESET | waiting one cycle after reset release
//   S_RUN   | fetching
module rv_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  input  logic        f_stall_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_bra_target_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic        f_valid_o
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  resp_pc;
  logic [1:0]   out_cnt;
  logic [1:0]   drop_cnt;

  logic         bra;
  logic         resp_good;
  logic         resp_stale;
  logic         out_load;
  logic         issue;
  logic [1:0]   out_cnt_nxt;
  logic [1:0]   st_cnt_nxt;
  logic [2:0]   slots_used;
  logic [31:0]  fetch_pc;

  logic         st_push;
  logic         st_pop;
  logic         st_flush;
  logic         st_empty;
  logic [1:0]   st_cnt;
  fetch_entry_t st_head;
  fetch_entry_t resp_entry;

  logic         unused_tgt;
  assign unused_tgt = ^x_bra_target_i[1:0];

  assign resp_entry = '{pc: resp_pc, ir: im_data_i};

`ifdef URV_FETCH_BUFFER_EN
  logic st_full;

  rv_fetch_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (st_push),
    .pop     (st_pop),
    .flush   (st_flush),
    .din     (resp_entry),
    .dout    (st_head),
    .full    (st_full),
    .empty   (st_empty)
  );

  assign st_cnt = st_full ? 2'd2 : (st_empty ? 2'd0 : 2'd1);
`else
  logic         hold_valid;
  fetch_entry_t hold_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || st_flush) hold_valid <= 1'b0;
    else if (st_push)         hold_valid <= 1'b1;
    else if (st_pop)          hold_valid <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (st_push) hold_q <= resp_entry;
  end

  assign st_head  = hold_q;
  assign st_empty = !hold_valid;
  assign st_cnt   = {1'b0, hold_valid};
`endif

  // A response skips the buffer only when nothing older is waiting and decode can take it now.
  always_comb begin
    bra         = x_bra_i && (state == S_RUN);
    resp_good   = im_valid_i && (drop_cnt == 2'd0) && !bra;
    resp_stale  = im_valid_i && (drop_cnt != 2'd0);
    out_load    = !f_stall_i && !bra;
    st_flush    = bra;
    st_pop      = out_load && !st_empty;
    st_push     = resp_good && (f_stall_i || !st_empty);
    out_cnt_nxt = out_cnt + {1'b0, im_rd_o} - {1'b0, im_valid_i};
    st_cnt_nxt  = bra ? 2'd0 : (st_cnt + {1'b0, st_push} - {1'b0, st_pop});
    fetch_pc    = bra ? {x_bra_target_i[31:2], 2'b00} : pc;
    slots_used  = {1'b0, out_cnt_nxt} + {1'b0, st_cnt_nxt};
`ifdef URV_FETCH_BUFFER_EN
    issue       = (state == S_RUN) && (slots_used < MAX_OUT);
`else
    issue       = (state == S_RUN) && (slots_used < MAX_OUT) && !(f_stall_i && !bra);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= S_RESET;
      pc        <= RESET_VECTOR;
      resp_pc   <= RESET_VECTOR;
      out_cnt   <= 2'd0;
      drop_cnt  <= 2'd0;
      im_rd_o   <= 1'b0;
      im_addr_o <= RESET_VECTOR;
      f_valid_o <= 1'b0;
      f_ir_o    <= RV_NOP;
      f_pc_o    <= RESET_VECTOR;
    end else begin
      case (state)
        S_RESET: begin
          state   <= S_RUN;
          pc      <= RESET_VECTOR;
          resp_pc <= RESET_VECTOR;
        end
        S_RUN: begin
          out_cnt <= out_cnt_nxt;
          im_rd_o <= issue;
          if (issue) im_addr_o <= fetch_pc;
          pc <= issue ? next_pc(fetch_pc) : fetch_pc;
          if (bra) begin
            drop_cnt  <= out_cnt_nxt;
            resp_pc   <= fetch_pc;
            f_valid_o <= 1'b0;
          end else begin
            if (resp_stale) drop_cnt <= drop_cnt - 2'd1;
            if (resp_good)  resp_pc  <= next_pc(resp_pc);
            if (out_load) begin
              if (!st_empty) begin
                f_valid_o <= 1'b1;
                f_pc_o    <= st_head.pc;
                f_ir_o    <= st_head.ir;
              end else if (resp_good) begin
                f_valid_o <= 1'b1;
                f_pc_o    <= resp_pc;
                f_ir_o    <= im_data_i;
              end else begin
                f_valid_o <= 1'b0;
              end
            end
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_fetch.sv
// Self-checking bench for rv_fetch: latency-configurable memory model plus expected-PC scoreboard.
module tb_rv_fetch;

  localparam logic [31:0] RV = 32'h0000_0100;
`ifdef URV_FETCH_BUFFER_EN
  localparam int MAXO = 2;
`else
  localparam int MAXO = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i;
  logic        im_valid_i;
  logic        f_stall_i;
  logic        x_bra_i;
  logic [31:0] x_bra_target_i;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_valid_o;

  always #5 clk_i = ~clk_i;

  rv_fetch #(.RESET_VECTOR(RV)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .im_addr_o      (im_addr_o),
    .im_rd_o        (im_rd_o),
    .im_data_i      (im_data_i),
    .im_valid_i     (im_valid_i),
    .f_stall_i      (f_stall_i),
    .x_bra_i        (x_bra_i),
    .x_bra_target_i (x_bra_target_i),
    .f_ir_o         (f_ir_o),
    .f_pc_o         (f_pc_o),
    .f_valid_o      (f_valid_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] tgt;
    int          lat;
    logic        st;
    logic        sync;
    logic        fill;
    logic        chk_issue;
    logic [31:0] exp_pc;
  } vec_t;

  req_t        pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  int          cyc, lat, errors, checks;
  logic        hold_chk;
  logic [64:0] hold_val;
  vec_t        vt[5];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    exp_next = {start[31:2], 2'b00};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exp_next);
      exp_next += 32'd4;
    end
  endtask

  // One cycle: drive inputs, serve memory, score outputs, advance to the next negedge.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    logic [31:0] e;
    f_stall_i      = st;
    x_bra_i        = br;
    x_bra_target_i = tgt;
    if (!rst_n_i) begin
      pend.delete();
      im_valid_i = 1'b0;
      im_data_i  = 32'h0;
    end else begin
      if (im_rd_o) pend.push_back('{addr: im_addr_o, due: cyc + lat});
      checks++;
      if (pend.size() > MAXO) begin
        errors++;
        $display("FAIL outstanding: got %0d allowed %0d (cycle %0d)", pend.size(), MAXO, cyc);
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        im_valid_i = 1'b1;
        im_data_i  = memfn(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        im_valid_i = 1'b0;
        im_data_i  = 32'hDEAD_BEEF;
      end
    end
    if (hold_chk) chk("stall_hold", {f_valid_o, f_pc_o, f_ir_o}, hold_val);
    hold_chk = st && !br && rst_n_i;
    hold_val = {f_valid_o, f_pc_o, f_ir_o};
    if (rst_n_i && f_valid_o && !st && !br) begin
      e = exp_q.pop_front();
      if (exp_q.size() < 4) begin
        exp_q.push_back(exp_next);
        exp_next += 32'd4;
      end
      chk("stream_pc", f_pc_o, e);
      chk("stream_ir", f_ir_o, memfn(e));
    end
    if (br) sb_restart(tgt);
    if (!rst_n_i) sb_restart(RV);
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!f_valid_o && n < 40) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk(name, f_valid_o, 1'b1);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; lat = 1; hold_chk = 1'b0; hold_val = '0;
    rst_n_i = 1'b0; f_stall_i = 1'b0; x_bra_i = 1'b0; x_bra_target_i = 32'h0;
    im_valid_i = 1'b0; im_data_i = 32'h0;
    vt[0] = '{32'h0000_0200, 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200};
    vt[1] = '{32'h0000_0303, 1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300};
    vt[2] = '{32'hFFFF_FFF8, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8};
    vt[3] = '{32'h0000_0044, 2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0044};
    vt[4] = '{32'h0000_1000, 2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000};
    sb_restart(RV);
    @(negedge clk_i);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    chk("rst_valid", f_valid_o, 1'b0);
    chk("rst_ir", f_ir_o, 32'h0000_0013);
    chk("rst_pc", f_pc_o, RV);
    chk("rst_rd", im_rd_o, 1'b0);
    chk("rst_addr", im_addr_o, RV);

    rst_n_i = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    chk("first_rd_c1", im_rd_o, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk("first_rd_c2", im_rd_o, 1'b1);
    chk("first_addr", im_addr_o, RV);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("latency_valid", f_valid_o, 1'b1);
    chk("latency_pc", f_pc_o, RV);

    // Freeze decode on PC 0x108 for five cycles.
    for (int i = 0; i < 30; i++) begin
      if (f_valid_o && f_pc_o == 32'h108) break;
      step(1'b0, 1'b0, 32'h0);
    end
    chk("find_108", {f_valid_o, f_pc_o}, {1'b1, 32'h108});
    repeat (5) step(1'b1, 1'b0, 32'h0);
    chk("stall_pc", {f_valid_o, f_pc_o}, {1'b1, 32'h108});
    step(1'b0, 1'b0, 32'h0);
    wait_valid("resume_wait");
    chk("resume_pc", f_pc_o, 32'h10C);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    for (int k = 0; k < 5; k++) begin
      int n;
      lat = vt[k].lat;
      repeat (6) step(1'b0, 1'b0, 32'h0);
      n = 0;
      while (n < 40 &&
             !((!vt[k].fill || (pend.size() + int'(im_rd_o)) >= MAXO) &&
               (!vt[k].sync || (pend.size() > 0 && pend[0].due <= cyc)))) begin
        step(1'b0, 1'b0, 32'h0);
        n++;
      end
      step(vt[k].st, 1'b1, vt[k].tgt);
      chk("bra_invalid", f_valid_o, 1'b0);
      if (vt[k].chk_issue) begin
        chk("bra_issue_rd", im_rd_o, 1'b1);
        chk("bra_issue_addr", im_addr_o, vt[k].exp_pc);
      end
      wait_valid("bra_wait");
      chk("bra_first_pc", f_pc_o, vt[k].exp_pc);
      repeat (8) step(1'b0, 1'b0, 32'h0);
    end

    // Second redirect while the first is still draining.
    lat = 3;
    repeat (6) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0500);
    step(1'b0, 1'b1, 32'h0000_0600);
    chk("dbl_invalid", f_valid_o, 1'b0);
    wait_valid("dbl_wait");
    chk("dbl_first_pc", f_pc_o, 32'h0000_0600);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // One-cycle reset in the middle of a 3-cycle-latency stream.
    rst_n_i = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    rst_n_i = 1'b1;
    chk("mid_rst_valid", f_valid_o, 1'b0);
    chk("mid_rst_rd", im_rd_o, 1'b0);
    chk("mid_rst_drop", dut.drop_cnt, 2'd0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("restart_rd", im_rd_o, 1'b1);
    chk("restart_addr", im_addr_o, RV);
    wait_valid("restart_wait");
    chk("restart_pc", f_pc_o, RV);
    repeat (10) step(1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
